// File: rtl/vga_pkg.sv
// Shared VGA timing constants and the RGB332 -> RGB444 colour expansion used by scan-out.
package vga_pkg;

  localparam int VGA_H_ACTIVE = 640;
  localparam int VGA_H_FP     = 16;
  localparam int VGA_H_SYNC   = 96;
  localparam int VGA_H_BP     = 48;
  localparam int VGA_V_ACTIVE = 480;
  localparam int VGA_V_FP     = 10;
  localparam int VGA_V_SYNC   = 2;
  localparam int VGA_V_BP     = 33;

  localparam int FB_W = 320;
  localparam int FB_H = 240;

  typedef struct packed {
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
  } rgb444_t;

  // Replicate the top bits so full-scale 3-bit and 2-bit codes map to 4'hF.
  function automatic rgb444_t rgb332_to_444(input logic [7:0] px);
    rgb444_t c;
    c.r = {px[7:5], px[7]};
    c.g = {px[4:2], px[4]};
    c.b = {px[1:0], px[1:0]};
    return c;
  endfunction

endpackage

// File: rtl/vga_scanout_if.sv
// Framebuffer read port seen from the scan-out stage: address out, RGB332 data back.
interface vga_scanout_if #(
  parameter int ADDR_WIDTH = 17
);
  logic [ADDR_WIDTH-1:0] addrb;
  logic [7:0]            doutb;

  modport master (output addrb, input doutb);
  modport slave  (input addrb, output doutb);
endinterface

// File: rtl/vga_timing.sv
// Pixel-tick divider, h/v raster counters, raw (undelayed) syncs and the frame-start pulse.
module vga_timing
  import vga_pkg::*;
#(
  parameter int CLK_DIV  = 4,
  parameter int H_ACTIVE = VGA_H_ACTIVE,
  parameter int H_FP     = VGA_H_FP,
  parameter int H_SYNC   = VGA_H_SYNC,
  parameter int H_BP     = VGA_H_BP,
  parameter int V_ACTIVE = VGA_V_ACTIVE,
  parameter int V_FP     = VGA_V_FP,
  parameter int V_SYNC   = VGA_V_SYNC,
  parameter int V_BP     = VGA_V_BP,
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP,
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP,
  localparam int HW      = $clog2(H_TOTAL),
  localparam int VW      = $clog2(V_TOTAL)
) (
  input  logic          clk,
  input  logic          rst_n,
  output logic          tick_o,
  output logic [HW-1:0] h_o,
  output logic [VW-1:0] v_o,
  output logic          active_o,
  output logic          hs_raw_o,
  output logic          vs_raw_o,
  output logic          h_wrap_o,
  output logic          v_wrap_o,
  output logic          frame_start_o
);

  localparam int DW = $clog2(CLK_DIV);
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_ACT    = HW'(H_ACTIVE);
  localparam logic [HW-1:0] HS_BEG   = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] HS_END   = HW'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_ACT    = VW'(V_ACTIVE);
  localparam logic [VW-1:0] VS_BEG   = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] VS_END   = VW'(V_ACTIVE + V_FP + V_SYNC - 1);

  logic [DW-1:0] div_q, div_d;
  logic [HW-1:0] h_q, h_d;
  logic [VW-1:0] v_q, v_d;
  logic          fs_q, fs_d;

  assign tick_o   = (div_q == DIV_LAST);
  assign h_wrap_o = tick_o && (h_q == H_LAST);
  assign v_wrap_o = h_wrap_o && (v_q == V_LAST);

  always_comb begin
    div_d = tick_o ? '0 : div_q + DW'(1);
    h_d   = h_q;
    v_d   = v_q;
    if (h_wrap_o) begin
      h_d = '0;
      v_d = v_wrap_o ? '0 : v_q + VW'(1);
    end else if (tick_o) begin
      h_d = h_q + HW'(1);
    end
    // High for the one clk after the tick that lands on pixel (0,0).
    fs_d = v_wrap_o;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q <= '0;
      h_q   <= '0;
      v_q   <= '0;
      fs_q  <= 1'b0;
    end else begin
      div_q <= div_d;
      h_q   <= h_d;
      v_q   <= v_d;
      fs_q  <= fs_d;
    end
  end

  assign h_o           = h_q;
  assign v_o           = v_q;
  assign active_o      = (h_q < H_ACT) && (v_q < V_ACT);
  assign hs_raw_o      = !((h_q >= HS_BEG) && (h_q <= HS_END));
  assign vs_raw_o      = !((v_q >= VS_BEG) && (v_q <= VS_END));
  assign frame_start_o = fs_q;

endmodule

// File: rtl/vga_scanout.sv
// VGA scan-out: 2x2-replicated framebuffer walk and one-pixel registered colour/sync output.
module vga_scanout
  import vga_pkg::*;
#(
  parameter int ADDR_WIDTH = 17,
  parameter int CLK_DIV    = 4,
  parameter int RD_LATENCY = 1,
  parameter int H_ACTIVE   = VGA_H_ACTIVE,
  parameter int H_FP       = VGA_H_FP,
  parameter int H_SYNC     = VGA_H_SYNC,
  parameter int H_BP       = VGA_H_BP,
  parameter int V_ACTIVE   = VGA_V_ACTIVE,
  parameter int V_FP       = VGA_V_FP,
  parameter int V_SYNC     = VGA_V_SYNC,
  parameter int V_BP       = VGA_V_BP
) (
  input  logic           clk,
  input  logic           rst_n,
  vga_scanout_if.master  fb,
  output logic           vga_hs,
  output logic           vga_vs,
  output logic [3:0]     vga_r,
  output logic [3:0]     vga_g,
  output logic [3:0]     vga_b,
  output logic           frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW      = $clog2(H_TOTAL);
  localparam int VW      = $clog2(V_TOTAL);
  localparam logic [ADDR_WIDTH-1:0] ROW_STEP   = ADDR_WIDTH'(H_ACTIVE / 2);
  localparam logic [VW-1:0]         V_LAST_ACT = VW'(V_ACTIVE - 1);

  if (CLK_DIV < 2 || RD_LATENCY > CLK_DIV - 1) begin : g_cfg_latency
    $error("vga_scanout: need CLK_DIV >= 2 and RD_LATENCY <= CLK_DIV-1");
  end
  if ((H_ACTIVE / 2) * (V_ACTIVE / 2) > (1 << ADDR_WIDTH) || FB_W * FB_H > (1 << ADDR_WIDTH))
  begin : g_cfg_addr
    $error("vga_scanout: ADDR_WIDTH too small for the framebuffer");
  end

  logic          tick, active, hs_raw, vs_raw, h_wrap, v_wrap;
  logic [HW-1:0] h;
  logic [VW-1:0] v;

  vga_timing #(
    .CLK_DIV  (CLK_DIV),
    .H_ACTIVE (H_ACTIVE),
    .H_FP     (H_FP),
    .H_SYNC   (H_SYNC),
    .H_BP     (H_BP),
    .V_ACTIVE (V_ACTIVE),
    .V_FP     (V_FP),
    .V_SYNC   (V_SYNC),
    .V_BP     (V_BP)
  ) u_timing (
    .clk           (clk),
    .rst_n         (rst_n),
    .tick_o        (tick),
    .h_o           (h),
    .v_o           (v),
    .active_o      (active),
    .hs_raw_o      (hs_raw),
    .vs_raw_o      (vs_raw),
    .h_wrap_o      (h_wrap),
    .v_wrap_o      (v_wrap),
    .frame_start_o (frame_start)
  );

  // Stage 0: row base advances once per pair of lines, so no multiply is needed.
  logic [ADDR_WIDTH-1:0] row_base_q, row_base_d;

  always_comb begin
    row_base_d = row_base_q;
    if (v_wrap) begin
      row_base_d = '0;
    end else if (h_wrap && v[0] && (v < V_LAST_ACT)) begin
      row_base_d = row_base_q + ROW_STEP;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) row_base_q <= '0;
    else        row_base_q <= row_base_d;
  end

  assign fb.addrb = active ? (row_base_q + ADDR_WIDTH'(h >> 1)) : '0;

  // Stage 1: read data lands one pixel after its address; syncs are delayed to match.
  rgb444_t rgb_p1_q, rgb_p1_d;
  logic    vld_p1_q, hs_p1_q, vs_p1_q;

  always_comb begin
    rgb_p1_d = rgb_p1_q;
    if (tick) rgb_p1_d = rgb332_to_444(fb.doutb);
  end

  always_ff @(posedge clk) begin
    rgb_p1_q <= rgb_p1_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1_q <= 1'b0;
      hs_p1_q  <= 1'b1;
      vs_p1_q  <= 1'b1;
    end else if (tick) begin
      vld_p1_q <= active;
      hs_p1_q  <= hs_raw;
      vs_p1_q  <= vs_raw;
    end
  end

  assign vga_hs = hs_p1_q;
  assign vga_vs = vs_p1_q;
  assign vga_r  = vld_p1_q ? rgb_p1_q.r : 4'h0;
  assign vga_g  = vld_p1_q ? rgb_p1_q.g : 4'h0;
  assign vga_b  = vld_p1_q ? rgb_p1_q.b : 4'h0;

endmodule

// File: tb/tb_vga_scanout.sv
// Directed bench: full-size raster for line-level checks, shrunken raster for frame-level checks.
module tb_vga_scanout;

  logic       clk     = 1'b0;
  logic       rst_n   = 1'b0;
  logic [7:0] doutb_tb = 8'hE0;

  always #5 clk = ~clk;

  vga_scanout_if #(.ADDR_WIDTH(17)) fb_full ();
  vga_scanout_if #(.ADDR_WIDTH(17)) fb_small ();
  assign fb_full.doutb  = doutb_tb;
  assign fb_small.doutb = doutb_tb;

  logic       f_hs, f_vs, f_fs, s_hs, s_vs, s_fs;
  logic [3:0] f_r, f_g, f_b, s_r, s_g, s_b;

  vga_scanout dut_full (
    .clk(clk), .rst_n(rst_n), .fb(fb_full),
    .vga_hs(f_hs), .vga_vs(f_vs), .vga_r(f_r), .vga_g(f_g), .vga_b(f_b),
    .frame_start(f_fs)
  );

  // 24x15-pixel raster (16x8 active): line = 96 clks, frame = 1440 clks.
  vga_scanout #(
    .ADDR_WIDTH(17), .CLK_DIV(4), .RD_LATENCY(1),
    .H_ACTIVE(16), .H_FP(2), .H_SYNC(4), .H_BP(2),
    .V_ACTIVE(8),  .V_FP(2), .V_SYNC(2), .V_BP(3)
  ) dut_small (
    .clk(clk), .rst_n(rst_n), .fb(fb_small),
    .vga_hs(s_hs), .vga_vs(s_vs), .vga_r(s_r), .vga_g(s_g), .vga_b(s_b),
    .frame_start(s_fs)
  );

  int n_pass = 0;
  int n_fail = 0;
  int n_total = 0;
  int e = 0;
  int s_vs_falls = 0;
  int s_fs_clks = 0;
  int snap_falls = 0;
  int snap_fs = 0;

  always @(negedge s_vs) if (rst_n === 1'b1) s_vs_falls = s_vs_falls + 1;
  always @(posedge clk) if (s_fs === 1'b1) s_fs_clks = s_fs_clks + 1;

  task automatic to_edge(input int target);
    while (e < target) begin
      @(posedge clk);
      e = e + 1;
    end
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total = n_total + 1;
    assert (obs === exp) n_pass = n_pass + 1;
    else begin
      n_fail = n_fail + 1;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int exp_addr(input int h, input int v);
    return (h < 640 && v < 480) ? (v / 2) * 320 + h / 2 : 0;
  endfunction

  initial begin
    repeat (5) @(posedge clk);
    #1;
    chk("rst_addr",   fb_full.addrb, 0);
    chk("rst_hs",     f_hs, 1);
    chk("rst_vs",     f_vs, 1);
    chk("rst_rgb",    {f_r, f_g, f_b}, 12'h000);
    chk("rst_fs",     f_fs, 0);
    chk("rst_s_vs",   s_vs, 1);

    rst_n = 1'b1;
    e = 0;
    chk("addr_h0",    fb_full.addrb, exp_addr(0, 0));
    to_edge(2);  chk("tick_clk2", dut_full.u_timing.tick_o, 0);
    to_edge(3);  chk("tick_clk3", dut_full.u_timing.tick_o, 1);
    to_edge(4);  chk("addr_h1",   fb_full.addrb, 0);
    to_edge(8);  chk("addr_h2",   fb_full.addrb, 1);
    to_edge(12); chk("addr_h3",   fb_full.addrb, 1);
    to_edge(16); chk("addr_h4",   fb_full.addrb, 2);
    to_edge(20); chk("addr_h5",   fb_full.addrb, 2);

    to_edge(40); chk("rgb_E0",    {f_r, f_g, f_b}, 12'hF00);
    doutb_tb = 8'h1C;
    to_edge(48); chk("rgb_1C",    {f_r, f_g, f_b}, 12'h0F0);
    doutb_tb = 8'h03;
    to_edge(56); chk("rgb_03",    {f_r, f_g, f_b}, 12'h00F);
    doutb_tb = 8'h92;
    to_edge(64); chk("rgb_92",    {f_r, f_g, f_b}, 12'h99A);

    to_edge(728);  chk("s_addr_14_7", fb_small.addrb, 31);
    to_edge(732);  chk("s_addr_last", fb_small.addrb, 31);
    to_edge(736);  chk("s_addr_blank", fb_small.addrb, 0);
    to_edge(963);  chk("s_vs_pre",   s_vs, 1);
    to_edge(964);  chk("s_vs_fall",  s_vs, 0);
    to_edge(1155); chk("s_vs_low",   s_vs, 0);
    to_edge(1156); chk("s_vs_rise",  s_vs, 1);
    to_edge(1439); chk("s_fs_pre",   s_fs, 0);
    to_edge(1440); chk("s_fs_on",    s_fs, 1);
    chk("s_fs_addr0", fb_small.addrb, 0);
    to_edge(1441); chk("s_fs_off",   s_fs, 0);
    to_edge(2403); chk("s_vs_pre2",  s_vs, 1);
    to_edge(2404); chk("s_vs_fall2", s_vs, 0);

    to_edge(2556); chk("addr_639_0", fb_full.addrb, exp_addr(639, 0));
    to_edge(2560); chk("addr_640_0", fb_full.addrb, 0);
    chk("rgb_last_act", {f_r, f_g, f_b}, 12'h99A);
    to_edge(2564); chk("rgb_blank",  {f_r, f_g, f_b}, 12'h000);
    to_edge(2627); chk("hs_pre",     f_hs, 1);
    to_edge(2628); chk("hs_fall",    f_hs, 0);
    to_edge(3011); chk("hs_low_end", f_hs, 0);
    to_edge(3012); chk("hs_rise",    f_hs, 1);
    to_edge(3200); chk("addr_0_1",   fb_full.addrb, exp_addr(0, 1));
    to_edge(3208); chk("addr_2_1",   fb_full.addrb, exp_addr(2, 1));
    to_edge(5827); chk("hs_pre_l1",  f_hs, 1);
    to_edge(5828); chk("hs_fall_l1", f_hs, 0);
    to_edge(6400); chk("addr_0_2",   fb_full.addrb, 320);
    chk("vs_idle",    f_vs, 1);
    to_edge(6404); chk("addr_1_2",   fb_full.addrb, 320);
    to_edge(6408); chk("addr_2_2",   fb_full.addrb, 321);

    to_edge(6800);
    chk("pre_rst_s_vs",   s_vs, 0);
    chk("pre_rst_rgb",    {f_r, f_g, f_b}, 12'h99A);
    chk("pre_rst_addr",   fb_full.addrb, 370);
    chk("s_vs_falls_5fr", s_vs_falls, 5);
    chk("s_fs_clks_4fr",  s_fs_clks, 4);
    snap_falls = s_vs_falls;
    snap_fs    = s_fs_clks;

    #2 rst_n = 1'b0;
    #1;
    chk("arst_s_vs",  s_vs, 1);
    chk("arst_hs",    f_hs, 1);
    chk("arst_rgb",   {f_r, f_g, f_b}, 12'h000);
    chk("arst_addr",  fb_full.addrb, 0);
    chk("arst_s_fs",  s_fs, 0);

    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    e = 0;
    chk("rel_addr_h0", fb_full.addrb, 0);
    to_edge(8);    chk("rel_addr_h2",  fb_full.addrb, 1);
    to_edge(963);  chk("rel_s_vs_pre", s_vs, 1);
    to_edge(964);  chk("rel_s_vs_fall", s_vs, 0);
    to_edge(1440); chk("rel_s_fs_on",  s_fs, 1);
    to_edge(1442);
    chk("rel_vs_falls", s_vs_falls - snap_falls, 1);
    chk("rel_fs_clks",  s_fs_clks - snap_fs, 1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
